// File: rtl/led_pkg.sv
// Shared constants, types and FSM encoding for the LED zone-mean pipeline.
// Zones are laid out 4 columns x 2 rows; zone index = row*4 + col.
package led_pkg;

    localparam int ZONE_NUM  = 8;
    localparam int ZONE_COLS = 4;
    localparam int ZONE_ROWS = 2;
    localparam int MEAN_W    = 4;
    localparam int CH_NUM    = 3;

    // One 4-bit mean per zone; element [z] belongs to zone z.
    typedef logic [ZONE_NUM-1:0][MEAN_W-1:0] mean_arr_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DIV,
        DONE
    } fsm_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_mean_div.sv
// One colour channel's zone mean: sum * reciprocal, rounded to nearest and
// saturated to 8 bits. Purely combinational; the parent time-shares it.
module led_mean_div #(
    parameter int                   SUM_W       = 10,
    parameter int                   RECIP_SHIFT = 32,
    parameter logic [RECIP_SHIFT:0] RECIP       = '0
) (
    input  logic [SUM_W-1:0] sum,
    output logic [7:0]       mean
);

    localparam int PROD_W = SUM_W + RECIP_SHIFT + 1;
    localparam int QUO_W  = PROD_W - RECIP_SHIFT;

    logic [PROD_W-1:0] prod;
    logic [QUO_W-1:0]  quo;

    always_comb begin
        prod = PROD_W'(sum) * PROD_W'(RECIP) + (PROD_W'(1) << (RECIP_SHIFT - 1));
        quo  = prod[PROD_W-1:RECIP_SHIFT];
        mean = (|quo[QUO_W-1:8]) ? 8'hFF : quo[7:0];
    end

endmodule

// File: rtl/led_zone_mean.sv
// Accumulates per-zone R/G/B sums over a frame, then divides one zone per
// cycle and publishes the 4-bit means together with a one-cycle start pulse.
//
// state | meaning
// IDLE  | waiting for a valid start-of-frame pixel
// ACC   | accumulating pixels into the current zone's sums
// DIV   | eight cycles, one zone per cycle, computing shadow means
// DONE  | publish shadow means, pulse start if enabled
module led_zone_mean
    import led_pkg::*;
#(
    parameter int H_ACT       = 1920,
    parameter int V_ACT       = 1080,
    parameter int RECIP_SHIFT = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              pix_valid,
    input  logic                              pix_sof,
    input  logic [7:0]                        pix_r,
    input  logic [7:0]                        pix_g,
    input  logic [7:0]                        pix_b,
    output logic [ZONE_NUM-1:0][MEAN_W-1:0]   MeanR,
    output logic [ZONE_NUM-1:0][MEAN_W-1:0]   MeanG,
    output logic [ZONE_NUM-1:0][MEAN_W-1:0]   MeanB,
    output logic                              start,
    output logic                              busy
);

    localparam int ZONE_W   = H_ACT / ZONE_COLS;
    localparam int ZONE_H   = V_ACT / ZONE_ROWS;
    localparam int ZONE_PIX = ZONE_W * ZONE_H;
    localparam int SUM_W    = 8 + $clog2(ZONE_PIX);
    localparam int ZX_W     = clog2_min1(ZONE_W);
    localparam int ZY_W     = clog2_min1(ZONE_H);

    // Rounded reciprocal: floor((2^S + N/2) / N) equals round(2^S / N).
    localparam logic [63:0] RECIP_64 =
        ((64'd1 << RECIP_SHIFT) + 64'(ZONE_PIX / 2)) / 64'(ZONE_PIX);
    localparam logic [RECIP_SHIFT:0] RECIP = RECIP_64[RECIP_SHIFT:0];

    fsm_t                                   state;
    logic [ZX_W-1:0]                        zx;
    logic [1:0]                             col;
    logic [ZY_W-1:0]                        zy;
    logic                                   row;
    logic [2:0]                             k;
    logic                                   sof_pend;
    logic [ZONE_NUM-1:0][CH_NUM-1:0][SUM_W-1:0] acc;
    logic [ZONE_NUM-1:0][CH_NUM-1:0][SUM_W-1:0] snap;
    mean_arr_t [CH_NUM-1:0]                 shadow;
    mean_arr_t [CH_NUM-1:0]                 mean_q;

    logic [CH_NUM-1:0][7:0]                 pix;
    logic [CH_NUM-1:0][7:0]                 div_mean;
    logic                                   sof_hit;
    logic                                   take;
    logic                                   last;
    logic                                   zx_end;
    logic                                   col_end;
    logic                                   zy_end;
    logic [ZX_W-1:0]                        cur_zx, nxt_zx;
    logic [1:0]                             cur_col, nxt_col;
    logic [ZY_W-1:0]                        cur_zy, nxt_zy;
    logic                                   cur_row, nxt_row;
    logic [2:0]                             zone;

    assign pix   = {pix_b, pix_g, pix_r};
    assign MeanR = mean_q[0];
    assign MeanG = mean_q[1];
    assign MeanB = mean_q[2];

    // A start-of-frame pixel is treated as position (0,0) regardless of the counters.
    always_comb begin
        sof_hit = pix_valid && pix_sof && (state == IDLE || state == ACC);
        take    = pix_valid && (state == ACC || sof_hit);
        cur_zx  = sof_hit ? '0   : zx;
        cur_col = sof_hit ? 2'd0 : col;
        cur_zy  = sof_hit ? '0   : zy;
        cur_row = sof_hit ? 1'b0 : row;
        zone    = {cur_row, cur_col};
        zx_end  = (cur_zx == ZX_W'(ZONE_W - 1));
        col_end = zx_end && (cur_col == 2'd3);
        zy_end  = col_end && (cur_zy == ZY_W'(ZONE_H - 1));
        last    = zy_end && cur_row;
        nxt_zx  = zx_end ? '0 : cur_zx + 1'b1;
        nxt_col = zx_end ? cur_col + 2'd1 : cur_col;
        nxt_zy  = col_end ? (zy_end ? '0 : cur_zy + 1'b1) : cur_zy;
        nxt_row = zy_end ? ~cur_row : cur_row;
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_div
        led_mean_div #(
            .SUM_W      (SUM_W),
            .RECIP_SHIFT(RECIP_SHIFT),
            .RECIP      (RECIP)
        ) u_div (
            .sum (snap[k][c]),
            .mean(div_mean[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            zx       <= '0;
            col      <= '0;
            zy       <= '0;
            row      <= 1'b0;
            k        <= '0;
            sof_pend <= 1'b0;
            acc      <= '0;
            snap     <= '0;
            shadow   <= '0;
            mean_q   <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE, ACC: begin
                    if (take) begin
                        zx  <= nxt_zx;
                        col <= nxt_col;
                        zy  <= nxt_zy;
                        row <= nxt_row;
                        if (last) begin
                            for (int z = 0; z < ZONE_NUM; z++)
                                for (int c = 0; c < CH_NUM; c++)
                                    snap[z][c] <= acc[z][c] +
                                        ((3'(z) == zone) ? SUM_W'(pix[c]) : '0);
                            acc   <= '0;
                            k     <= '0;
                            busy  <= 1'b1;
                            state <= DIV;
                        end else if (sof_hit) begin
                            acc <= '0;
                            for (int c = 0; c < CH_NUM; c++)
                                acc[0][c] <= SUM_W'(pix[c]);
                            state <= ACC;
                        end else begin
                            for (int c = 0; c < CH_NUM; c++)
                                acc[zone][c] <= acc[zone][c] + SUM_W'(pix[c]);
                        end
                    end
                end
                DIV: begin
                    for (int c = 0; c < CH_NUM; c++)
                        shadow[c][k] <= div_mean[c][7:4];
                    k <= k + 3'd1;
                    if (k == 3'd7)
                        state <= DONE;
                    if (pix_valid && pix_sof)
                        sof_pend <= 1'b1;
                end
                DONE: begin
                    mean_q   <= shadow;
                    start    <= en;
                    busy     <= 1'b0;
                    sof_pend <= 1'b0;
                    // Counters and accumulators were already cleared at frame end.
                    state    <= (sof_pend || (pix_valid && pix_sof)) ? ACC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
